// File: rtl/fp_pkg.sv
// Shared definitions for the float<->int converters: IEEE-754 single field
// widths, 32-bit integer limits, the common converter state encoding and the
// operand classification used by float_to_int.
package fp_pkg;

  localparam int FP_EXP_W    = 8;
  localparam int FP_MAN_W    = 23;
  localparam int FP_EXP_BIAS = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Sequencing shared by both converter directions.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UNPACK  = 3'd1,
    ST_ALIGN   = 3'd2,
    ST_CONVERT = 3'd3,
    ST_DONE    = 3'd4
  } conv_state_e;

  // Operand classes that pick how the integer result is formed.
  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_SMALL  = 3'd1,
    CLS_BIG    = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } fp_class_e;

  // NaN/Inf take priority; the all-ones exponent would otherwise look "big".
  function automatic fp_class_e fp_classify(
    input logic [FP_EXP_W-1:0] exp,
    input logic [FP_MAN_W-1:0] man,
    input logic signed [8:0]   e
  );
    fp_class_e cls;
    if (exp == 8'hFF && man != '0) begin
      cls = CLS_NAN;
    end else if (exp == 8'hFF) begin
      cls = CLS_INF;
    end else if (e < 9'sd0) begin
      cls = CLS_SMALL;
    end else if (e >= 9'sd31) begin
      cls = CLS_BIG;
    end else begin
      cls = CLS_NORMAL;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational bidirectional barrel shift that places the 24-bit significand
// at its integer weight. Bits shifted out on the right are dropped, which is
// what makes the conversion truncate toward zero.
module fp_align_shifter
  import fp_pkg::*;
(
  input  logic [FP_MAN_W:0] sig_i,
  input  logic signed [8:0] e_i,
  output logic [31:0]       mag_o
);

  logic [31:0] sig_ext;
  logic [4:0]  lsh;
  logic [4:0]  rsh;

  // Shift distances only need 5 bits over the range where they are used.
  assign sig_ext = {8'b0, sig_i};
  assign lsh     = e_i[4:0] - 5'd23;
  assign rsh     = 5'd23 - e_i[4:0];

  // Left shift for e in [23,31], right shift for e in [0,22]; outside that
  // range the caller substitutes a class-specific result, so return zero.
  always_comb begin
    mag_o = '0;
    if (e_i >= 9'sd23 && e_i <= 9'sd31) begin
      mag_o = sig_ext << lsh;
    end else if (e_i >= 9'sd0 && e_i < 9'sd23) begin
      mag_o = sig_ext >> rsh;
    end
  end

endmodule

// File: rtl/float_to_int.sv
// Sequential IEEE-754 single -> signed 32-bit integer converter.
// Truncates toward zero, saturates on overflow, maps NaN to NAN_VALUE.
//
// Handshake: an operand is taken on a rising edge where input_a_stb and
// input_a_ack are both high; a result is handed off on a rising edge where
// output_z_stb and output_z_ack are both high. Only one operation is in
// flight, so input_a_ack stays low from acceptance until handoff. All
// outputs are driven straight from registers.
module float_to_int
  import fp_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic        output_ovf,
  output logic [2:0]  state_dbg_o
);

  conv_state_e         state_q, state_d;
  logic                ack_q, ack_d;
  logic                stb_q, stb_d;
  logic [31:0]         a_q, a_d;
  logic                s_q, s_d;
  logic [FP_MAN_W-1:0] man_q, man_d;
  logic signed [8:0]   e_q, e_d;
  fp_class_e           cls_q, cls_d;
  logic [31:0]         mag_q, mag_d;
  logic [31:0]         z_q, z_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         shift_mag;

  fp_align_shifter u_shift (
    .sig_i (({1'b1, man_q})),
    .e_i   (e_q),
    .mag_o (shift_mag)
  );

  // State and datapath registers; reset discards any in-flight operand.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      stb_q   <= 1'b0;
      a_q     <= '0;
      s_q     <= 1'b0;
      man_q   <= '0;
      e_q     <= '0;
      cls_q   <= CLS_SMALL;
      mag_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      stb_q   <= stb_d;
      a_q     <= a_d;
      s_q     <= s_d;
      man_q   <= man_d;
      e_q     <= e_d;
      cls_q   <= cls_d;
      mag_q   <= mag_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state and per-stage datapath updates; everything holds by default.
  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    stb_d   = stb_q;
    a_d     = a_q;
    s_d     = s_q;
    man_d   = man_q;
    e_d     = e_q;
    cls_d   = cls_q;
    mag_d   = mag_q;
    z_d     = z_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        // ack comes up one edge after reset release or after a handoff.
        ack_d = 1'b1;
        if (input_a_stb && ack_q) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        s_d     = a_q[31];
        man_d   = a_q[FP_MAN_W-1:0];
        e_d     = 9'({1'b0, a_q[30:23]}) - 9'(FP_EXP_BIAS);
        cls_d   = fp_classify(a_q[30:23], a_q[FP_MAN_W-1:0], e_d);
        state_d = ST_ALIGN;
      end
      ST_ALIGN: begin
        mag_d   = shift_mag;
        state_d = ST_CONVERT;
      end
      ST_CONVERT: begin
        case (cls_q)
          CLS_NAN: begin
            z_d   = NAN_VALUE;
            ovf_d = 1'b1;
          end
          CLS_INF: begin
            z_d   = s_q ? INT32_MIN : INT32_MAX;
            ovf_d = 1'b1;
          end
          CLS_SMALL: begin
            // Sign is ignored: -0.0 and negative fractions become +0.
            z_d   = '0;
            ovf_d = 1'b0;
          end
          CLS_BIG: begin
            // -2^31 is the one big value that is exactly representable.
            if (s_q && e_q == 9'sd31 && man_q == '0) begin
              z_d   = INT32_MIN;
              ovf_d = 1'b0;
            end else begin
              z_d   = s_q ? INT32_MIN : INT32_MAX;
              ovf_d = 1'b1;
            end
          end
          default: begin
            z_d   = s_q ? (~mag_q + 32'd1) : mag_q;
            ovf_d = 1'b0;
          end
        endcase
        stb_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ack_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = z_q;
  assign output_ovf   = ovf_q;
  assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int. A second instance with NAN_VALUE = 0
// shares every input with the main instance, so both run in lockstep.
module tb_float_to_int;
  import fp_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;
  logic        output_ovf;
  logic [2:0]  state_dbg;

  logic        ack2;
  logic [31:0] z2;
  logic        stb2;
  logic        ovf2;
  logic [2:0]  state2;

  int n_vec = 0;
  int n_err = 0;

  float_to_int dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack),
    .output_ovf   (output_ovf),
    .state_dbg_o  (state_dbg)
  );

  float_to_int #(.NAN_VALUE(32'h0000_0000)) dut_nan0 (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (ack2),
    .output_z     (z2),
    .output_z_stb (stb2),
    .output_z_ack (output_z_ack),
    .output_ovf   (ovf2),
    .state_dbg_o  (state2)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "timeout");
  end

  // Driver: wait (bounded) for ack, present the operand for one edge, then
  // scramble input_a to show later changes are ignored. Ends at E0+1.
  task automatic send_op(input logic [31:0] a, output bit ok);
    int waited = 0;
    ok = 1'b1;
    while (input_a_ack !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (input_a_ack !== 1'b1) ok = 1'b0;
    input_a     = a;
    input_a_stb = 1'b1;
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = $urandom;
  endtask

  // Count edges after acceptance until output_z_stb is seen (bounded).
  task automatic wait_stb(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk); #1;
      cycles++;
    end while (output_z_stb !== 1'b1 && cycles < 20);
  endtask

  task automatic handoff();
    output_z_ack = 1'b1;
    @(posedge clk); #1;
    output_z_ack = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (output_z !== 32'h0 || output_ovf !== 1'b0 || output_z_stb !== 1'b0 || input_a_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: z=%h ovf=%b stb=%b ack=%b, required 0/0/0/0",
               output_z, output_ovf, output_z_stb, input_a_ack);
    end
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if (input_a_ack !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ack_before_edge: ack=%b required 0", input_a_ack);
    end
    @(posedge clk); #1;
    n_vec++;
    if (input_a_ack !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ack_first_edge: ack=%b required 1", input_a_ack);
    end
  endtask

  task automatic test_basic();
    logic [31:0] vin [6] = '{32'h3F80_0000, 32'hC020_0000, 32'h4B7F_FFFF,
                             32'h42F6_E979, 32'hC2F6_E979, 32'h4EFF_FFFF};
    logic [31:0] vz  [6] = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h00FF_FFFF,
                             32'h0000_007B, 32'hFFFF_FF85, 32'h7FFF_FF80};
    bit ok;
    int cyc;
    for (int i = 0; i < 6; i++) begin
      send_op(vin[i], ok);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL basic_ack_wait[%0d]: ack never rose", i);
      end
      wait_stb(cyc);
      n_vec++;
      if (cyc != 3) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: stb after %0d edges, required 3", i, cyc);
      end
      n_vec++;
      if (output_z !== vz[i] || output_ovf !== 1'b0 || input_a_ack !== 1'b0) begin
        n_err++;
        $display("FAIL basic_result[%0d] in=%h: z=%h ovf=%b ack=%b, required z=%h ovf=0 ack=0",
                 i, vin[i], output_z, output_ovf, input_a_ack, vz[i]);
      end
      handoff();
      n_vec++;
      if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
        n_err++;
        $display("FAIL basic_handoff[%0d]: stb=%b ack=%b, required stb=0 ack=1",
                 i, output_z_stb, input_a_ack);
      end
    end
  endtask

  // output_z_ack is held high before the result appears.
  task automatic test_small();
    logic [31:0] vin [5] = '{32'h3F7F_FFFF, 32'h8000_0000, 32'h0000_0001,
                             32'h3F00_0000, 32'hBF7F_FFFF};
    bit ok;
    int cyc;
    for (int i = 0; i < 5; i++) begin
      output_z_ack = 1'b1;
      send_op(vin[i], ok);
      wait_stb(cyc);
      n_vec++;
      if (!ok || cyc != 3 || output_z !== 32'h0 || output_ovf !== 1'b0) begin
        n_err++;
        $display("FAIL small[%0d] in=%h: ok=%0d cyc=%0d z=%h ovf=%b, required ok=1 cyc=3 z=0 ovf=0",
                 i, vin[i], ok, cyc, output_z, output_ovf);
      end
      @(posedge clk); #1;
      output_z_ack = 1'b0;
      n_vec++;
      if (output_z_stb !== 1'b0) begin
        n_err++;
        $display("FAIL small_early_ack[%0d]: stb=%b required 0", i, output_z_stb);
      end
    end
  endtask

  task automatic test_saturate();
    logic [31:0] vin [5] = '{32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000,
                             32'h7F80_0000, 32'hCF00_0001};
    logic [31:0] vz  [5] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                             32'h7FFF_FFFF, 32'h8000_0000};
    logic        vo  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bit ok;
    int cyc;
    for (int i = 0; i < 5; i++) begin
      send_op(vin[i], ok);
      wait_stb(cyc);
      n_vec++;
      if (!ok || cyc != 3 || output_z !== vz[i] || output_ovf !== vo[i]) begin
        n_err++;
        $display("FAIL saturate[%0d] in=%h: cyc=%0d z=%h ovf=%b, required cyc=3 z=%h ovf=%b",
                 i, vin[i], cyc, output_z, output_ovf, vz[i], vo[i]);
      end
      handoff();
    end
  endtask

  task automatic test_nan();
    logic [31:0] vin [2] = '{32'h7FC0_0000, 32'hFF80_0001};
    bit ok;
    int cyc;
    for (int i = 0; i < 2; i++) begin
      send_op(vin[i], ok);
      wait_stb(cyc);
      n_vec++;
      if (!ok || cyc != 3 || output_z !== 32'h8000_0000 || output_ovf !== 1'b1) begin
        n_err++;
        $display("FAIL nan_default[%0d] in=%h: cyc=%0d z=%h ovf=%b, required cyc=3 z=80000000 ovf=1",
                 i, vin[i], cyc, output_z, output_ovf);
      end
      n_vec++;
      if (stb2 !== 1'b1 || z2 !== 32'h0 || ovf2 !== 1'b1) begin
        n_err++;
        $display("FAIL nan_zero_param[%0d] in=%h: stb=%b z=%h ovf=%b, required stb=1 z=00000000 ovf=1",
                 i, vin[i], stb2, z2, ovf2);
      end
      handoff();
    end
  endtask

  // Result held under back-pressure while a new operand waits; the waiting
  // operand is taken on the edge right after the handoff.
  task automatic test_back_to_back();
    bit ok;
    int cyc;
    send_op(32'h42F6_E979, ok);
    wait_stb(cyc);
    input_a     = 32'h3F80_0000;
    input_a_stb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (output_z !== 32'h0000_007B || output_ovf !== 1'b0 || output_z_stb !== 1'b1 || input_a_ack !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: z=%h ovf=%b stb=%b ack=%b, required z=0000007b ovf=0 stb=1 ack=0",
                 i, output_z, output_ovf, output_z_stb, input_a_ack);
      end
    end
    handoff();
    n_vec++;
    if (output_z_stb !== 1'b0 || input_a_ack !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_handoff: stb=%b ack=%b, required stb=0 ack=1", output_z_stb, input_a_ack);
    end
    @(posedge clk); #1;
    input_a_stb = 1'b0;
    input_a     = 32'hFFFF_FFFF;
    n_vec++;
    if (input_a_ack !== 1'b0 || state_dbg !== ST_UNPACK) begin
      n_err++;
      $display("FAIL pending_accept: ack=%b state=%0d, required ack=0 state=%0d",
               input_a_ack, state_dbg, ST_UNPACK);
    end
    wait_stb(cyc);
    n_vec++;
    if (cyc != 3 || output_z !== 32'h0000_0001 || output_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL pending_result: cyc=%0d z=%h ovf=%b, required cyc=3 z=00000001 ovf=0",
               cyc, output_z, output_ovf);
    end
    handoff();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    send_op(32'hC2F6_E979, ok);
    @(posedge clk); #1;
    n_vec++;
    if (state_dbg !== ST_ALIGN) begin
      n_err++;
      $display("FAIL mid_reach_align: state=%0d required %0d", state_dbg, ST_ALIGN);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if (output_z !== 32'h0 || output_ovf !== 1'b0 || output_z_stb !== 1'b0 ||
        input_a_ack !== 1'b0 || state_dbg !== ST_IDLE) begin
      n_err++;
      $display("FAIL mid_reset_outputs: z=%h ovf=%b stb=%b ack=%b state=%0d, required all 0",
               output_z, output_ovf, output_z_stb, input_a_ack, state_dbg);
    end
    #2 rst = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (input_a_ack !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_ack: ack=%b required 1", input_a_ack);
    end
    send_op(32'hC0FC_CCCD, ok);
    wait_stb(cyc);
    n_vec++;
    if (!ok || cyc != 3 || output_z !== 32'hFFFF_FFF9 || output_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_next_op: cyc=%0d z=%h ovf=%b, required cyc=3 z=fffffff9 ovf=0",
               cyc, output_z, output_ovf);
    end
    handoff();
  endtask

  initial begin
    rst          = 1'b0;
    input_a      = '0;
    input_a_stb  = 1'b0;
    output_z_ack = 1'b0;
    test_reset();
    test_basic();
    test_small();
    test_saturate();
    test_nan();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/float_to_int.md
# float_to_int

Sequential IEEE-754 single-precision to signed 32-bit integer converter; the inverse stage of the integer-to-float converter. It sits downstream of the floating-point datapath and returns results to the integer domain. Conversion truncates toward zero and saturates on overflow. It uses a strobe/acknowledge handshake on input and output, with a fixed 3-cycle compute latency and unbounded output back-pressure.

## Interface
- `NAN_VALUE`, default `32'h8000_0000`: integer result produced for any NaN input.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (`rst == 0` resets).
- `input_a` input 32: IEEE-754 single operand; sampled only on acceptance.
- `input_a_stb` input 1: upstream holds operand valid.
- `input_a_ack` output 1: block ready; acceptance = `input_a_stb & input_a_ack` at a rising edge.
- `output_z` output 32: signed two's-complement result.
- `output_z_stb` output 1: result valid.
- `output_z_ack` input 1: downstream consumes; handoff = `output_z_stb & output_z_ack` at a rising edge.
- `output_ovf` output 1: result was saturated or NaN; valid with `output_z_stb`.

## Operation
- States: IDLE → UNPACK → ALIGN → CONVERT → DONE → IDLE.
- **IDLE**
  - `input_a_ack = 1`.
  - On acceptance: register `input_a`, drop ack, go to UNPACK.
- **UNPACK**
  - Split into sign `s`, biased exponent `exp`[7:0], fraction `man`[22:0].
  - Unbiased exponent `e = exp - 127`, held as a 9-bit signed value.
  - Classify the operand: NaN (`exp==255`, `man!=0`), Inf (`exp==255`, `man==0`), small (`e<0`; this covers ±0 and denormals), big (`e>=31`), normal.
- **ALIGN**
  - Significand `sig = {1'b1, man}` (24 bits).
  - Magnitude `mag` (32 bits) = `sig << (e-23)` when `e>=23`, otherwise `sig >> (23-e)`.
  - Fraction bits shifted out are discarded (truncation).
- **CONVERT**
  - NaN → `NAN_VALUE`, ovf=1.
  - Inf → `s ? 32'h8000_0000 : 32'h7FFF_FFFF`, ovf=1.
  - Small → 0, ovf=0. Negative zero and negative fractions also give +0.
  - Big: if `s==1`, `e==31` and `man==0` → `32'h8000_0000` with ovf=0 (exact INT_MIN). Otherwise saturate by sign, ovf=1.
  - Normal → `s ? -mag : mag`, ovf=0.
  - `output_z` and `output_ovf` are registered at this edge.
- **DONE**
  - `output_z_stb = 1`.
  - `output_z` and `output_ovf` hold stable until handoff.
  - On handoff: `output_z_stb` drops and the state returns to IDLE.
  - `input_a_ack` stays 0 throughout DONE; only one operation is in flight.
- **Reset** (async assert, any state)
  - State goes to IDLE; the in-flight operand is discarded.
  - `output_z = 0`, `output_ovf = 0`, `output_z_stb = 0`, `input_a_ack = 0`.
  - `input_a_ack` rises on the first rising edge after `rst` deasserts.

## Timing
- Acceptance at edge E0. `output_z_stb` rises at edge E3 with valid data.
- Fastest repeat: handoff at E3+1, then IDLE, ack=1 in the next cycle. Minimum initiation interval is 5 cycles.
- `output_z_ack` asserted before `output_z_stb` is legal. Handoff occurs on the first edge where both are high.
- `input_a_stb` deasserting while `input_a_ack=0` has no effect. Changes to `input_a` after acceptance are ignored.
- All outputs come directly from registers; there are no combinational input→output paths.

## Structure
- Shared package `fp_pkg` holds:
  - field-width constants: `FP_EXP_W=8`, `FP_MAN_W=23`, `FP_EXP_BIAS=127`;
  - integer limits: `INT32_MAX`, `INT32_MIN`;
  - the state enum used by both float/int converters.
- One sub-module: `fp_align_shifter`. It is combinational and takes `sig` and `e`, returning `mag` (bidirectional barrel shift, truncating).

## Test plan
- Basic values, each followed by immediate ack: `3F800000` (1.0) → `00000001`, ovf=0; `C0200000` (-2.5) → `FFFFFFFE`; `4B7FFFFF` → `00FFFFFF`. Check stb at exactly E3.
- Small inputs: `3F7FFFFF`, `80000000` (-0.0) and denormal `00000001` all → `00000000`, ovf=0.
- Saturation and Inf: `4F000000` (2^31) → `7FFFFFFF` with ovf=1; `CF000000` → `80000000` with ovf=0; `FF800000` (-Inf) → `80000000` with ovf=1.
- NaN: `7FC00000` → `80000000`, ovf=1. Repeat with `NAN_VALUE=0` → `00000000`.
- Back-pressure: hold `output_z_ack` low for 10 cycles. `output_z` and `output_ovf` stay stable, `output_z_stb` stays high, `input_a_ack` stays low, and a pending `input_a_stb` is not accepted until after handoff.
- Reset mid-operation: assert `rst` low in ALIGN. All outputs go to 0 immediately. After release, ack=1 at the next edge and the next operand converts correctly.
